// File: rtl/or1k_boot_pkg.sv
// Shared definitions for the OR1K boot sequencer: state encoding and word-size helper.
package or1k_boot_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RD      = 3'd2,
        ST_WR      = 3'd3,
        ST_CHK     = 3'd4,
        ST_RELEASE = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } boot_state_e;

    function automatic int word_bytes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/or1k_boot_wb_writer.sv
// Single Wishbone classic write with ack timeout and bus-error detection.
// Shared by the RAM clear and image copy phases of or1k_boot_sequencer.
module or1k_boot_wb_writer #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_ack,
    input  logic          i_err,
    output logic [AW-1:0] o_adr,
    output logic [DW-1:0] o_dat,
    output logic          o_cyc,
    output logic          o_ok,
    output logic          o_fail
);
    localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    logic          r_cyc;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_dat;
    logic [TW-1:0] r_tmo;
    logic          w_tc;

    assign w_tc   = (r_tmo == '0);
    // err wins over a coincident ack; timeout fires on the last allowed cycle without ack
    assign o_ok   = r_cyc & i_ack & ~i_err;
    assign o_fail = r_cyc & (i_err | (w_tc & ~i_ack));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_tmo <= '0;
        end else if (r_cyc) begin
            if (o_ok || o_fail) begin
                r_cyc <= 1'b0;
            end else begin
                r_tmo <= r_tmo - TW'(1);
            end
        end else if (i_start) begin
            r_cyc <= 1'b1;
            r_adr <= i_addr;
            r_dat <= i_data;
            r_tmo <= TW'(ACK_TIMEOUT);
        end
    end

    assign o_adr = r_adr;
    assign o_dat = r_dat;
    assign o_cyc = r_cyc;

endmodule

// File: rtl/or1k_boot_sequencer.sv
// Boot sequencer: optional RAM clear, ROM-to-RAM image copy over Wishbone, staggered reset release.
// Optional image checksum compare is enabled by defining OR1K_BOOT_CHECKSUM_EN.
//
// state      | meaning
// INIT       | latch clear/length, range-check length
// CLEAR      | zero-fill RAM one word per write
// RD         | phase 0 presents rom_addr, phase 1 captures ROM word and starts write
// WR         | Wishbone write of the captured word
// CHK        | compare accumulated image sum (checksum build only)
// RELEASE    | staggered deassertion of downstream resets
// DONE       | all channels released (terminal)
// ERR        | bus error, timeout, oversize or checksum mismatch (terminal)
module or1k_boot_sequencer
    import or1k_boot_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MEM_SIZE     = 32'h02000000,
    parameter int RST_CHANNELS = 2,
    parameter int RELEASE_GAP  = 16,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    clear_ram_i,
    input  logic [AW-1:0]           img_words_i,
`ifdef OR1K_BOOT_CHECKSUM_EN
    input  logic [31:0]             expected_sum_i,
`endif
    output logic [AW-1:0]           rom_addr_o,
    input  logic [DW-1:0]           rom_data_i,
    output logic [AW-1:0]           wbm_adr_o,
    output logic [DW-1:0]           wbm_dat_o,
    output logic [DW/8-1:0]         wbm_sel_o,
    output logic                    wbm_we_o,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    output logic [RST_CHANNELS-1:0] rst_o,
    output logic                    done_o,
    output logic                    error_o
);
    localparam int            WB  = word_bytes(DW);
    localparam logic [AW-1:0] CAP = AW'(MEM_SIZE / WB);
`ifdef OR1K_BOOT_CHECKSUM_EN
    localparam boot_state_e ST_COPY_END = ST_CHK;
`else
    localparam boot_state_e ST_COPY_END = ST_RELEASE;
`endif

    boot_state_e             r_state;
    logic [AW-1:0]           r_len;
    logic [AW-1:0]           r_idx;
    logic [AW-1:0]           r_rom_addr;
    logic [AW-1:0]           r_rel_cnt;
    logic                    r_rd_ph;
    logic [RST_CHANNELS-1:0] r_rst;
    logic                    r_done;
    logic                    r_err;
`ifdef OR1K_BOOT_CHECKSUM_EN
    logic [31:0]             r_sum;
`endif

    logic          w_start;
    logic          w_ok;
    logic          w_fail;
    logic [AW-1:0] w_idx_nxt;
    logic [AW-1:0] w_wr_adr;
    logic [DW-1:0] w_wr_dat;

    assign w_idx_nxt = r_idx + AW'(1);
    assign w_wr_adr  = r_idx * AW'(WB);
    assign w_wr_dat  = (r_state == ST_CLEAR) ? '0 : rom_data_i;
    // CLEAR restarts once the writer is idle, which yields the single idle cycle between words
    assign w_start   = ((r_state == ST_CLEAR) && !wbm_cyc_o) || ((r_state == ST_RD) && r_rd_ph);

    or1k_boot_wb_writer #(
        .AW          (AW),
        .DW          (DW),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_writer (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_start (w_start),
        .i_addr  (w_wr_adr),
        .i_data  (w_wr_dat),
        .i_ack   (wbm_ack_i),
        .i_err   (wbm_err_i),
        .o_adr   (wbm_adr_o),
        .o_dat   (wbm_dat_o),
        .o_cyc   (wbm_cyc_o),
        .o_ok    (w_ok),
        .o_fail  (w_fail)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_INIT;
            r_len      <= '0;
            r_idx      <= '0;
            r_rom_addr <= '0;
            r_rel_cnt  <= '0;
            r_rd_ph    <= 1'b0;
            r_rst      <= '1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef OR1K_BOOT_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_len <= img_words_i;
                    r_idx <= '0;
`ifdef OR1K_BOOT_CHECKSUM_EN
                    r_sum <= '0;
`endif
                    if (img_words_i > CAP) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end else if (clear_ram_i) begin
                        r_state <= ST_CLEAR;
                    end else if (img_words_i == '0) begin
                        r_state <= ST_COPY_END;
                    end else begin
                        r_state <= ST_RD;
                    end
                end
                ST_CLEAR: begin
                    if (w_fail) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end else if (w_ok) begin
                        if (r_idx == CAP - AW'(1)) begin
                            r_idx   <= '0;
                            r_rd_ph <= 1'b0;
                            r_state <= (r_len == '0) ? ST_COPY_END : ST_RD;
                        end else begin
                            r_idx <= w_idx_nxt;
                        end
                    end
                end
                ST_RD: begin
                    r_rd_ph <= ~r_rd_ph;
                    if (r_rd_ph) r_state <= ST_WR;
                end
                ST_WR: begin
                    if (w_fail) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end else if (w_ok) begin
`ifdef OR1K_BOOT_CHECKSUM_EN
                        r_sum <= r_sum + wbm_dat_o[31:0];
`endif
                        r_idx <= w_idx_nxt;
                        if (w_idx_nxt == r_len) begin
                            r_state <= ST_COPY_END;
                        end else begin
                            r_rom_addr <= w_idx_nxt;
                            r_state    <= ST_RD;
                        end
                    end
                end
`ifdef OR1K_BOOT_CHECKSUM_EN
                ST_CHK: begin
                    if (r_sum == expected_sum_i) begin
                        r_state <= ST_RELEASE;
                    end else begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end
                end
`endif
                ST_RELEASE: begin
                    r_rel_cnt <= r_rel_cnt + AW'(1);
                    for (int k = 0; k < RST_CHANNELS; k++) begin
                        if (r_rel_cnt == AW'(RELEASE_GAP * (k + 1) - 1)) r_rst[k] <= 1'b0;
                    end
                    if (r_rel_cnt == AW'(RELEASE_GAP * RST_CHANNELS - 1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_DONE;
                ST_ERR:  r_state <= ST_ERR;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign rom_addr_o = r_rom_addr;
    assign wbm_sel_o  = '1;
    assign wbm_we_o   = wbm_cyc_o;
    assign wbm_stb_o  = wbm_cyc_o;
    assign rst_o      = r_rst;
    assign done_o     = r_done;
    assign error_o    = r_err;

endmodule

// File: tb/tb_or1k_boot_sequencer.sv
// Directed self-checking bench for or1k_boot_sequencer with a behavioural ROM and Wishbone slave.
// Checksum scenarios are included when OR1K_BOOT_CHECKSUM_EN is defined.
module tb_or1k_boot_sequencer;
    localparam int AW = 32, DW = 32, MEM_SIZE = 64, RST_CH = 2, GAP = 4, ACK_TO = 16;
`ifdef OR1K_BOOT_CHECKSUM_EN
    localparam int CHK_LAT = 1;
`else
    localparam int CHK_LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear_ram = 1'b0;
    logic [AW-1:0]     img_words = '0;
`ifdef OR1K_BOOT_CHECKSUM_EN
    logic [31:0]       exp_sum = '0;
`endif
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic [AW-1:0]     adr;
    logic [DW-1:0]     dat;
    logic [DW/8-1:0]   sel;
    logic              we, cyc, stb;
    logic              ack = 1'b0;
    logic              err = 1'b0;
    logic [RST_CH-1:0] rst_o;
    logic              done, error;

    logic [DW-1:0] rom [0:15];

    int passed = 0;
    int total  = 0;

    // slave / monitor state
    int            tick = 0;
    int            ack_lat = 1;
    bit            no_ack = 0;
    int            err_idx = -1;
    int            attempt, w, rises, run, run_max, low_run, gap_min, gap_max, busy, bad_sel;
    int            fault_pending, drop_cyc;
    logic          prev_cyc = 1'b0;
    logic [AW-1:0] rom_max;
    logic [AW-1:0] wr_adr [$];
    logic [DW-1:0] wr_dat [$];
    int            ack_tick [$];

    or1k_boot_sequencer #(
        .AW(AW), .DW(DW), .MEM_SIZE(MEM_SIZE), .RST_CHANNELS(RST_CH),
        .RELEASE_GAP(GAP), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .clear_ram_i    (clear_ram),
        .img_words_i    (img_words),
`ifdef OR1K_BOOT_CHECKSUM_EN
        .expected_sum_i (exp_sum),
`endif
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .wbm_adr_o      (adr),
        .wbm_dat_o      (dat),
        .wbm_sel_o      (sel),
        .wbm_we_o       (we),
        .wbm_cyc_o      (cyc),
        .wbm_stb_o      (stb),
        .wbm_ack_i      (ack),
        .wbm_err_i      (err),
        .rst_o          (rst_o),
        .done_o         (done),
        .error_o        (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick++;

    // ROM with one cycle of read latency
    always @(posedge clk) rom_data <= rom[rom_addr[3:0]];

    // Wishbone slave and bus monitor, evaluated on the falling edge
    always @(negedge clk) begin
        if (fault_pending != 0) begin
            drop_cyc = int'(cyc);
            fault_pending = 0;
        end
        if (rom_addr > rom_max) rom_max = rom_addr;
        if (cyc) begin
            busy++;
            if (sel !== 4'hF || we !== 1'b1 || stb !== 1'b1) bad_sel++;
            if (!prev_cyc) begin
                rises++;
                if (rises > 1) begin
                    if (low_run < gap_min) gap_min = low_run;
                    if (low_run > gap_max) gap_max = low_run;
                end
            end
            run++;
            if (run > run_max) run_max = run;
            low_run = 0;
        end else begin
            run = 0;
            low_run++;
        end
        prev_cyc = cyc;
        if (cyc && stb && !ack && !err) begin
            if (!no_ack && w >= ack_lat - 1) begin
                if (attempt == err_idx) begin
                    ack = 1'b1;
                    err = 1'b1;
                    fault_pending = 1;
                end else begin
                    ack = 1'b1;
                    wr_adr.push_back(adr);
                    wr_dat.push_back(dat);
                    ack_tick.push_back(tick);
                end
                attempt++;
            end else begin
                w++;
            end
        end else begin
            ack = 1'b0;
            err = 1'b0;
            w = 0;
        end
    end

    task automatic clear_stats();
        attempt = 0; w = 0; rises = 0; run = 0; run_max = 0; low_run = 0;
        gap_min = 1000; gap_max = 0; busy = 0; bad_sel = 0;
        fault_pending = 0; drop_cyc = 1; rom_max = '0;
        wr_adr.delete(); wr_dat.delete(); ack_tick.delete();
    endtask

    task automatic start_seq(input bit clr, input int words);
        logic [31:0] s;
        rst = 1'b1;
        clear_ram = clr;
        img_words = AW'(words);
        s = '0;
        for (int i = 0; i < words && i < 16; i++) s = s + rom[i];
`ifdef OR1K_BOOT_CHECKSUM_EN
        exp_sum = s;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear_stats();
        rst = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int c = 0; c < budget && !(done || error); c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ram = 1'b0;
        img_words = 3;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rst_o !== 2'b11) $display("FAIL reset_rst_o: got %b expected 11", rst_o); else passed++;
        total++; if ({cyc, stb, we} !== 3'b000) $display("FAIL reset_bus_ctl: got %b expected 000", {cyc, stb, we}); else passed++;
        total++; if (adr !== '0) $display("FAIL reset_adr: got %h expected 0", adr); else passed++;
        total++; if (dat !== '0) $display("FAIL reset_dat: got %h expected 0", dat); else passed++;
        total++; if (rom_addr !== '0) $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (error !== 1'b0) $display("FAIL reset_error: got %b expected 0", error); else passed++;
    endtask

    task automatic test_copy();
        int t_r0, t_r1, t_ack;
        rom[0] = 32'hA5A5_0001; rom[1] = 32'h5A5A_0002; rom[2] = 32'hC3C3_0003;
        ack_lat = 1; no_ack = 0; err_idx = -1;
        start_seq(1'b0, 3);
        t_r0 = -1; t_r1 = -1;
        for (int c = 0; c < 200 && !(done || error); c++) begin
            @(posedge clk); #1;
            if (t_r0 < 0 && rst_o[0] === 1'b0) t_r0 = tick;
            if (t_r1 < 0 && rst_o[1] === 1'b0) t_r1 = tick;
        end
        t_ack = (ack_tick.size() >= 3) ? ack_tick[2] : -100;
        total++; if (wr_adr.size() != 3) $display("FAIL copy_nwrites: got %0d expected 3", wr_adr.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= wr_adr.size() || wr_adr[i] !== 32'(i * 4) || wr_dat[i] !== rom[i])
                $display("FAIL copy_word%0d: got adr/dat differ from expected %h/%h", i, 32'(i * 4), rom[i]);
            else passed++;
        end
        // ack sampled at the end of tick n; channel 0 falls on the 4th following edge, seen at tick n+5
        total++; if (t_r0 - t_ack != 5 + CHK_LAT) $display("FAIL copy_rst0_delay: got %0d expected %0d", t_r0 - t_ack, 5 + CHK_LAT); else passed++;
        total++; if (t_r1 - t_r0 != GAP) $display("FAIL copy_rst1_gap: got %0d expected %0d", t_r1 - t_r0, GAP); else passed++;
        total++; if (gap_min != 2 || gap_max != 2) $display("FAIL copy_idle_gap: got %0d..%0d expected 2..2", gap_min, gap_max); else passed++;
        total++; if (bad_sel != 0) $display("FAIL copy_sel_we: got %0d bad cycles expected 0", bad_sel); else passed++;
        total++; if ({done, error, rst_o} !== 4'b1000) $display("FAIL copy_final: got %b expected 1000", {done, error, rst_o}); else passed++;
    endtask

    task automatic test_clear_empty();
        int bad;
        ack_lat = 1; no_ack = 0; err_idx = -1;
        start_seq(1'b1, 0);
        wait_end(300);
        bad = 0;
        for (int i = 0; i < wr_adr.size(); i++)
            if (wr_adr[i] !== 32'(i * 4) || wr_dat[i] !== '0) bad++;
        total++; if (wr_adr.size() != 16) $display("FAIL clear_nwrites: got %0d expected 16", wr_adr.size()); else passed++;
        total++; if (bad != 0) $display("FAIL clear_words: got %0d bad words expected 0", bad); else passed++;
        total++; if (gap_min != 1 || gap_max != 1) $display("FAIL clear_idle_gap: got %0d..%0d expected 1..1", gap_min, gap_max); else passed++;
        total++; if (rom_max !== '0) $display("FAIL clear_rom_addr: got %h expected 0", rom_max); else passed++;
        total++; if ({done, error, rst_o} !== 4'b1000) $display("FAIL clear_final: got %b expected 1000", {done, error, rst_o}); else passed++;
    endtask

    task automatic test_oversize();
        ack_lat = 1; no_ack = 0; err_idx = -1;
        start_seq(1'b1, 17);
        @(posedge clk); #1;
        total++; if (error !== 1'b1) $display("FAIL oversize_error_early: got %b expected 1", error); else passed++;
        repeat (20) @(posedge clk);
        #1;
        total++; if (busy != 0) $display("FAIL oversize_bus: got %0d busy cycles expected 0", busy); else passed++;
        total++; if ({done, error, rst_o} !== 4'b0111) $display("FAIL oversize_final: got %b expected 0111", {done, error, rst_o}); else passed++;
    endtask

    task automatic test_bus_err();
        ack_lat = 1; no_ack = 0; err_idx = 1;
        start_seq(1'b0, 3);
        wait_end(100);
        repeat (3) @(posedge clk);
        #1;
        err_idx = -1;
        total++; if (drop_cyc != 0) $display("FAIL buserr_drop: got cyc=%0d after err expected 0", drop_cyc); else passed++;
        total++; if ({done, error, rst_o} !== 4'b0111) $display("FAIL buserr_final: got %b expected 0111", {done, error, rst_o}); else passed++;
        total++; if (wr_adr.size() != 1 || rises != 2) $display("FAIL buserr_writes: got %0d ok/%0d started expected 1/2", wr_adr.size(), rises); else passed++;
        total++; if (cyc !== 1'b0) $display("FAIL buserr_idle: got cyc=%b expected 0", cyc); else passed++;
    endtask

    task automatic test_timeout();
        ack_lat = 1; no_ack = 1; err_idx = -1;
        start_seq(1'b0, 2);
        wait_end(100);
        repeat (3) @(posedge clk);
        #1;
        no_ack = 0;
        total++; if (run_max != ACK_TO + 1) $display("FAIL timeout_cyc_len: got %0d expected %0d", run_max, ACK_TO + 1); else passed++;
        total++; if ({done, error, rst_o} !== 4'b0111) $display("FAIL timeout_final: got %b expected 0111", {done, error, rst_o}); else passed++;
        total++; if (rises != 1 || cyc !== 1'b0) $display("FAIL timeout_bus: got %0d starts cyc=%b expected 1 starts cyc=0", rises, cyc); else passed++;
    endtask

    task automatic test_reset_midcycle();
        ack_lat = 3; no_ack = 0; err_idx = -1;
        rom[0] = 32'h1111_AAAA; rom[1] = 32'h2222_BBBB; rom[2] = 32'h3333_CCCC;
        start_seq(1'b0, 3);
        for (int c = 0; c < 60 && !(rises == 2 && cyc === 1'b1); c++) begin
            @(posedge clk); #1;
        end
        total++; if (!(rises == 2 && cyc === 1'b1)) $display("FAIL rstmid_reach_wr2: got %0d starts cyc=%b expected 2 starts cyc=1", rises, cyc); else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if ({cyc, stb} !== 2'b00) $display("FAIL rstmid_cyc_drop: got %b expected 00", {cyc, stb}); else passed++;
        total++; if (rst_o !== 2'b11 || adr !== '0) $display("FAIL rstmid_outputs: got rst_o=%b adr=%h expected 11/0", rst_o, adr); else passed++;
        clear_stats();
        rst = 1'b0;
        wait_end(100);
        total++;
        if (wr_adr.size() != 3 || wr_adr[0] !== '0 || wr_dat[0] !== rom[0])
            $display("FAIL rstmid_restart: got %0d writes, first differ from expected 0/%h", wr_adr.size(), rom[0]);
        else passed++;
        total++; if ({done, error} !== 2'b10) $display("FAIL rstmid_done: got %b expected 10", {done, error}); else passed++;
        ack_lat = 1;
    endtask

`ifdef OR1K_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        ack_lat = 1; no_ack = 0; err_idx = -1;
        rom[0] = 32'd1; rom[1] = 32'd2; rom[2] = 32'd3;
        start_seq(1'b0, 3);
        exp_sum = 32'd6;
        wait_end(100);
        total++; if ({done, error} !== 2'b10) $display("FAIL chk_match: got %b expected 10", {done, error}); else passed++;
        start_seq(1'b0, 3);
        exp_sum = 32'd7;
        wait_end(100);
        total++; if ({done, error, rst_o} !== 4'b0111) $display("FAIL chk_mismatch: got %b expected 0111", {done, error, rst_o}); else passed++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'hDEAD_0000 | 32'(i);
        clear_stats();
        test_reset();
        test_copy();
        test_clear_empty();
        test_oversize();
        test_bus_err();
        test_timeout();
        test_reset_midcycle();
`ifdef OR1K_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1);
    end

endmodule
